ex_forward_unit: RTL and testbench

Parametrised EX-stage operand forwarding unit. Successor to the fixed 2-operand, 3-way forwarding mux.
- Detects MEM→EX and WB→EX hazards internally.
- Raises a one-cycle load-use interlock.
- Keeps each forwarded operand in a hold register while EX is stalled, so operands survive when MEM/WB drain.
- Sits between the ID/EX pipeline register and EX_ALU / EX_ALU_Mux.

---
 rtl/ex_forward_unit.sv | 194 +++++++++++++++++++
 tb/tb_ex_forward_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_forward_unit.sv
// ex_forward_unit: EX-stage operand forwarding for NUM_SRC source operands.
// Resolves MEM->EX and WB->EX hazards combinationally, raises a one-cycle
// load-use interlock, and holds each resolved operand while EX is frozen so
// it survives MEM/WB draining underneath a stalled instruction.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module ex_forward_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  Src_Reg_EX,
  input  logic [NUM_SRC*DATA_W-1:0]      Read_Data_EX,
  input  logic                           Reg_Write_MEM,
  input  logic                           Mem_Read_MEM,
  input  logic [REG_ADDR_W-1:0]          Write_Reg_MEM,
  input  logic [DATA_W-1:0]              ALU_Result_MEM,
  input  logic                           Reg_Write_WB,
  input  logic [REG_ADDR_W-1:0]          Write_Reg_WB,
  input  logic [DATA_W-1:0]              Write_Data_WB,
  input  logic                           Stall_EX,
  output logic [NUM_SRC*DATA_W-1:0]      Operand_EX,
  output logic [NUM_SRC*2-1:0]           Forward_Sel_EX,
  output logic                           Load_Use_Stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                    Fwd_Mem_Count,
  output logic [31:0]                    Fwd_Wb_Count,
  output logic [31:0]                    Load_Use_Count
`endif
);

  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_RF   = 2'b00;
  localparam logic [SEL_W-1:0] SEL_WB   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b11;

  logic [NUM_SRC-1:0] pending;
  logic               freeze;

`ifdef FWD_STATS_EN
  localparam int unsigned CNT_W = 32;
  logic [NUM_SRC-1:0] is_mem;
  logic [NUM_SRC-1:0] is_wb;
`endif

  // Interlock: any operand waiting on a load in MEM freezes the front end
  assign Load_Use_Stall = |pending;
  assign freeze         = Stall_EX | Load_Use_Stall;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_op
      logic [REG_ADDR_W-1:0] src;
      logic [DATA_W-1:0]     rf_val;
      logic                  mem_hit;
      logic                  wb_hit;
      logic [SEL_W-1:0]      sel;
      logic [DATA_W-1:0]     val;
      logic                  hold_valid_q;
      logic                  hold_valid_d;
      logic [DATA_W-1:0]     hold_data_q;
      logic [DATA_W-1:0]     hold_data_d;

      assign src     = Src_Reg_EX[g*REG_ADDR_W +: REG_ADDR_W];
      assign rf_val  = Read_Data_EX[g*DATA_W +: DATA_W];
      assign mem_hit = Reg_Write_MEM & (Write_Reg_MEM == src) & (src != '0);
      assign wb_hit  = Reg_Write_WB  & (Write_Reg_WB  == src) & (src != '0);

      // A load result in MEM is not usable yet; a held operand never waits
      assign pending[g] = mem_hit & Mem_Read_MEM & ~hold_valid_q & ~Reset;

      // Source priority: held, MEM (non-load), WB, register file
      always_comb begin
        sel = SEL_RF;
        val = rf_val;
        if (!Reset) begin
          if (hold_valid_q) begin
            sel = SEL_HOLD;
            val = hold_data_q;
          end else if (mem_hit && !Mem_Read_MEM) begin
            sel = SEL_MEM;
            val = ALU_Result_MEM;
          end else if (wb_hit) begin
            sel = SEL_WB;
            val = Write_Data_WB;
          end
        end
      end

      assign Operand_EX[g*DATA_W +: DATA_W]   = val;
      assign Forward_Sel_EX[g*SEL_W +: SEL_W] = sel;

      // Capture on the first frozen cycle the operand is resolved, release when EX advances
      always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (freeze) begin
          if (!hold_valid_q && !pending[g]) begin
            hold_valid_d = 1'b1;
            hold_data_d  = val;
          end
        end else begin
          hold_valid_d = 1'b0;
        end
      end

      // Hold register state
      always_ff @(posedge Clk) begin
        if (Reset) begin
          hold_valid_q <= 1'b0;
          hold_data_q  <= '0;
        end else begin
          hold_valid_q <= hold_valid_d;
          hold_data_q  <= hold_data_d;
        end
      end

`ifdef FWD_STATS_EN
      logic [SEL_W-1:0] hold_code_q;
      logic [SEL_W-1:0] hold_code_d;
      logic [SEL_W-1:0] eff_code;

      // Remember the source a held operand originally came from
      always_comb begin
        hold_code_d = hold_code_q;
        if (freeze && !hold_valid_q && !pending[g]) begin
          hold_code_d = sel;
        end
      end

      // Capture-cycle source code register
      always_ff @(posedge Clk) begin
        if (Reset) begin
          hold_code_q <= SEL_RF;
        end else begin
          hold_code_q <= hold_code_d;
        end
      end

      assign eff_code  = (sel == SEL_HOLD) ? hold_code_q : sel;
      assign is_mem[g] = (eff_code == SEL_MEM);
      assign is_wb[g]  = (eff_code == SEL_WB);
`endif
    end
  endgenerate

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_mem_cnt_q;
  logic [CNT_W-1:0] fwd_mem_cnt_d;
  logic [CNT_W-1:0] fwd_wb_cnt_q;
  logic [CNT_W-1:0] fwd_wb_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q;
  logic [CNT_W-1:0] lu_cnt_d;
  logic [CNT_W:0]   mem_sum;
  logic [CNT_W:0]   wb_sum;

  // Saturating counter next-state
  always_comb begin
    mem_sum       = {1'b0, fwd_mem_cnt_q} + (CNT_W+1)'($countones(is_mem));
    wb_sum        = {1'b0, fwd_wb_cnt_q}  + (CNT_W+1)'($countones(is_wb));
    fwd_mem_cnt_d = fwd_mem_cnt_q;
    fwd_wb_cnt_d  = fwd_wb_cnt_q;
    lu_cnt_d      = lu_cnt_q;
    if (!freeze) begin
      fwd_mem_cnt_d = mem_sum[CNT_W] ? '1 : mem_sum[CNT_W-1:0];
      fwd_wb_cnt_d  = wb_sum[CNT_W]  ? '1 : wb_sum[CNT_W-1:0];
    end
    if (Load_Use_Stall && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fwd_mem_cnt_q <= '0;
      fwd_wb_cnt_q  <= '0;
      lu_cnt_q      <= '0;
    end else begin
      fwd_mem_cnt_q <= fwd_mem_cnt_d;
      fwd_wb_cnt_q  <= fwd_wb_cnt_d;
      lu_cnt_q      <= lu_cnt_d;
    end
  end

  assign Fwd_Mem_Count  = fwd_mem_cnt_q;
  assign Fwd_Wb_Count   = fwd_wb_cnt_q;
  assign Load_Use_Count = lu_cnt_q;
`endif

endmodule

// File: tb/tb_ex_forward_unit.sv
// Scoreboard bench for ex_forward_unit: directed cases plus randomized traffic
// checked against a behavioural forwarding model.
module tb_ex_forward_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic             Clk;
  logic             Reset;
  logic [NS*AW-1:0] src_reg;
  logic [NS*DW-1:0] rd_data;
  logic             rw_mem, mr_mem, rw_wb, stall_ex;
  logic [AW-1:0]    wr_mem, wr_wb;
  logic [DW-1:0]    alu_mem, wbd;
  logic [NS*DW-1:0] op_ex;
  logic [NS*2-1:0]  sel_ex;
  logic             lus;
`ifdef FWD_STATS_EN
  logic [31:0] fmc, fwc, luc;
`endif

  ex_forward_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Src_Reg_EX     (src_reg),
    .Read_Data_EX   (rd_data),
    .Reg_Write_MEM  (rw_mem),
    .Mem_Read_MEM   (mr_mem),
    .Write_Reg_MEM  (wr_mem),
    .ALU_Result_MEM (alu_mem),
    .Reg_Write_WB   (rw_wb),
    .Write_Reg_WB   (wr_wb),
    .Write_Data_WB  (wbd),
    .Stall_EX       (stall_ex),
    .Operand_EX     (op_ex),
    .Forward_Sel_EX (sel_ex),
    .Load_Use_Stall (lus)
`ifdef FWD_STATS_EN
    ,
    .Fwd_Mem_Count  (fmc),
    .Fwd_Wb_Count   (fwc),
    .Load_Use_Count (luc)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [NS*DW-1:0] op;
    logic [NS*2-1:0]  sel;
    logic             st;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state: which operands the stalled instruction already owns
  bit            m_hv[NS];
  logic [DW-1:0] m_hd[NS];
  logic [1:0]    m_hc[NS];
  longint        m_mem_cnt, m_wb_cnt, m_lu_cnt;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Evaluate the forwarding rules for the current inputs and advance model state
  task automatic model_step(output exp_t e);
    bit            pend[NS];
    logic [1:0]    code[NS];
    logic [DW-1:0] val[NS];
    bit            any_pend;
    bit            frz;
    logic [AW-1:0] s;
    bit            mh, wh;
    any_pend = 0;
    for (int i = 0; i < NS; i++) begin
      s  = src_reg[i*AW +: AW];
      mh = rw_mem && (wr_mem == s) && (s != 0);
      wh = rw_wb  && (wr_wb  == s) && (s != 0);
      pend[i] = !Reset && mh && mr_mem && !m_hv[i];
      if (Reset)                begin code[i] = 2'd0; val[i] = rd_data[i*DW +: DW]; end
      else if (m_hv[i])         begin code[i] = 2'd3; val[i] = m_hd[i]; end
      else if (mh && !mr_mem)   begin code[i] = 2'd2; val[i] = alu_mem; end
      else if (wh)              begin code[i] = 2'd1; val[i] = wbd; end
      else                      begin code[i] = 2'd0; val[i] = rd_data[i*DW +: DW]; end
      if (pend[i]) any_pend = 1;
      e.op[i*DW +: DW] = val[i];
      e.sel[i*2 +: 2]  = code[i];
    end
    e.st = any_pend;
    frz  = stall_ex || any_pend;
    if (Reset) begin
      m_mem_cnt = 0; m_wb_cnt = 0; m_lu_cnt = 0;
    end else begin
      if (any_pend) m_lu_cnt++;
      if (!frz) begin
        for (int i = 0; i < NS; i++) begin
          logic [1:0] c;
          c = (code[i] == 2'd3) ? m_hc[i] : code[i];
          if (c == 2'd2) m_mem_cnt++;
          if (c == 2'd1) m_wb_cnt++;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (Reset) begin
        m_hv[i] = 0; m_hd[i] = '0; m_hc[i] = 2'd0;
      end else if (frz) begin
        if (!m_hv[i] && !pend[i]) begin
          m_hv[i] = 1; m_hd[i] = val[i]; m_hc[i] = code[i];
        end
      end else begin
        m_hv[i] = 0;
      end
    end
  endtask

  // One clock of stimulus; hand-written expectations override the model's when given
  task automatic step(input bit hand, input logic [DW-1:0] o0, input logic [DW-1:0] o1,
                      input logic [1:0] s0, input logic [1:0] s1, input logic st);
    exp_t e;
    model_step(e);
    if (hand) begin
      e.op  = {o1, o0};
      e.sel = {s1, s0};
      e.st  = st;
    end
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic ops(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                     input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    src_reg = {s1, s0};
    rd_data = {r1, r0};
  endtask

  task automatic mem(input logic rw, input logic mr, input logic [AW-1:0] w, input logic [DW-1:0] d);
    rw_mem = rw; mr_mem = mr; wr_mem = w; alu_mem = d;
  endtask

  task automatic wb(input logic rw, input logic [AW-1:0] w, input logic [DW-1:0] d);
    rw_wb = rw; wr_wb = w; wbd = d;
  endtask

  // Monitor: the DUT presents a resolved operand set every cycle
  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("operand_ex", 64'(op_ex), 64'(mon_e.op));
      chk("forward_sel", 64'(sel_ex), 64'(mon_e.sel));
      chk("load_use_stall", 64'(lus), 64'(mon_e.st));
    end
  end

  initial begin
    Clk = 0;
    Reset = 1;
    stall_ex = 0;
    ops(0, 0, 0, 0);
    mem(0, 0, 0, 0);
    wb(0, 0, 0);
    for (int i = 0; i < NS; i++) begin
      m_hv[i] = 0; m_hd[i] = '0; m_hc[i] = 2'd0;
    end
    m_mem_cnt = 0; m_wb_cnt = 0; m_lu_cnt = 0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset forces regfile pass-through and no interlock
    Reset = 1; ops(3, 3, 32'hAAAA, 32'hBBBB); mem(1, 1, 3, 32'h11);
    step(1, 32'hAAAA, 32'hBBBB, 2'd0, 2'd0, 0);
    // MEM beats WB on the same register
    Reset = 0; ops(3, 1, 32'hAAAA, 32'hBBBB); mem(1, 0, 3, 32'h11); wb(1, 3, 32'h22);
    step(1, 32'h11, 32'hBBBB, 2'd2, 2'd0, 0);
    // Register 0 never forwards
    ops(0, 2, 0, 32'h20); mem(1, 0, 0, 32'h55); wb(1, 0, 32'h66);
    step(1, 0, 32'h20, 2'd0, 2'd0, 0);
    // Load-use: one-cycle interlock, then WB supplies the load data
    ops(7, 4, 32'h70, 32'h40); mem(1, 1, 4, 32'hDEAD); wb(0, 0, 0);
    step(1, 32'h70, 32'h40, 2'd0, 2'd0, 1);
    mem(0, 0, 0, 0); wb(1, 4, 32'h1234);
    step(1, 32'h70, 32'h1234, 2'd3, 2'd1, 0);
    ops(7, 4, 32'h71, 32'h41); wb(0, 0, 0);
    step(1, 32'h71, 32'h41, 2'd0, 2'd0, 0);
    // External stall holds a WB-forwarded value while WB moves on
    ops(5, 6, 32'h50, 32'h60); wb(1, 5, 32'hABCD); stall_ex = 1;
    step(1, 32'hABCD, 32'h60, 2'd1, 2'd0, 0);
    wb(1, 9, 32'h9999);
    step(1, 32'hABCD, 32'h60, 2'd3, 2'd3, 0);
    step(1, 32'hABCD, 32'h60, 2'd3, 2'd3, 0);
    stall_ex = 0;
    step(1, 32'hABCD, 32'h60, 2'd3, 2'd3, 0);
    step(1, 32'h50, 32'h60, 2'd0, 2'd0, 0);
    // Reset mid-stall discards held operands
    wb(1, 5, 32'hABCD); stall_ex = 1;
    step(1, 32'hABCD, 32'h60, 2'd1, 2'd0, 0);
    wb(1, 9, 32'h9999); Reset = 1;
    step(1, 32'h50, 32'h60, 2'd0, 2'd0, 0);
    Reset = 0;
    step(1, 32'h50, 32'h60, 2'd0, 2'd0, 0);
    stall_ex = 0;
    step(1, 32'h50, 32'h60, 2'd3, 2'd3, 0);
    // Pending load with a WB hit on the same register
    ops(8, 0, 32'h80, 0); mem(1, 1, 8, 32'hDEAD); wb(1, 8, 32'h88);
    step(1, 32'h88, 0, 2'd1, 2'd0, 1);
    mem(0, 0, 0, 0); wb(1, 8, 32'h8888);
    step(1, 32'h8888, 0, 2'd1, 2'd3, 0);
    // External stall overlapping a load-use: pending operand captured later
    ops(3, 4, 32'h30, 32'h40); mem(1, 1, 4, 32'hDEAD); wb(0, 0, 0); stall_ex = 1;
    step(1, 32'h30, 32'h40, 2'd0, 2'd0, 1);
    mem(0, 0, 0, 0); wb(1, 4, 32'h44);
    step(1, 32'h30, 32'h44, 2'd3, 2'd1, 0);
    wb(0, 0, 0);
    step(1, 32'h30, 32'h44, 2'd3, 2'd3, 0);
    stall_ex = 0;
    step(1, 32'h30, 32'h44, 2'd3, 2'd3, 0);
    step(1, 32'h30, 32'h40, 2'd0, 2'd0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      Reset    = ($urandom_range(0, 99) < 3);
      stall_ex = ($urandom_range(0, 99) < 20);
      ops(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom, $urandom);
      mem($urandom_range(0, 1), ($urandom_range(0, 99) < 30), AW'($urandom_range(0, 7)), $urandom);
      wb($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
      step(0, 0, 0, 2'd0, 2'd0, 0);
    end
    Reset = 0; stall_ex = 0; mem(0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 2'd0, 0);

    @(negedge Clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
`ifdef FWD_STATS_EN
    chk("fwd_mem_count", 64'(fmc), 64'(m_mem_cnt));
    chk("fwd_wb_count", 64'(fwc), 64'(m_wb_cnt));
    chk("load_use_count", 64'(luc), 64'(m_lu_cnt));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
